// File: rtl/stopwatch_display_mux.sv
// Multiplexed 3-digit seven-segment driver (minutes, seconds, tenths) with per-frame snapshot and blink.
// Latency: outputs registered one cycle after sel/shadow update; no backpressure, free-running scan.
module stopwatch_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] minutes_bcd,
    input  logic [3:0] seconds_bcd,
    input  logic [3:0] tenths_bcd,
    input  logic       flash,
    input  logic       blank_zero,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] SEL_TENTHS  = 2'd0;
    localparam logic [1:0] SEL_SECONDS = 2'd1;
    localparam logic [1:0] SEL_MINUTES = 2'd2;

    logic [PW-1:0] pre;
    logic [1:0]    sel;
    logic          tick;
    logic          snap;

    logic [3:0]    minutes_sh;
    logic [3:0]    seconds_sh;
    logic [3:0]    tenths_sh;
    logic          flash_sh;
    logic          blank_zero_sh;

    logic [FW-1:0] fcnt;
    logic          phase;

    logic [3:0]    digit;
    logic          blank_digit;
    logic          dark;
    logic [2:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick = (pre == PW'(REFRESH_DIV - 1));
    assign snap = tick && (sel == SEL_MINUTES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
            sel <= SEL_TENTHS;
        end else begin
            if (tick) begin
                pre <= '0;
                sel <= (sel == SEL_MINUTES) ? SEL_TENTHS : sel + 2'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            minutes_sh    <= '0;
            seconds_sh    <= '0;
            tenths_sh     <= '0;
            flash_sh      <= 1'b0;
            blank_zero_sh <= 1'b0;
        end else if (snap) begin
            minutes_sh    <= minutes_bcd;
            seconds_sh    <= seconds_bcd;
            tenths_sh     <= tenths_bcd;
            flash_sh      <= flash;
            blank_zero_sh <= blank_zero;
        end
    end

    // Counting only while the previous frame was already flashing makes the
    // first flashing frame start a full visible half-period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (snap) begin
            if (!flash) begin
                fcnt  <= '0;
                phase <= 1'b0;
            end else if (flash_sh) begin
                if (fcnt == FW'(BLINK_DIV - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    always_comb begin
        digit       = tenths_sh;
        blank_digit = 1'b0;
        case (sel)
            SEL_SECONDS: digit = seconds_sh;
            SEL_MINUTES: begin
                digit       = minutes_sh;
                blank_digit = blank_zero_sh && (minutes_sh == 4'd0);
            end
            default:     digit = tenths_sh;
        endcase
        dark    = flash_sh && phase;
        seg_nxt = blank_digit ? 7'h7F : bcd_to_seg(digit);
        an_nxt  = dark ? 3'b111 : ~(3'b001 << sel);
        dp_nxt  = (sel != SEL_SECONDS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= 3'b111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= snap;
        end
    end

endmodule
